button_pulse_debouncer: RTL and testbench

- Upstream conditioning stage for push-button inputs on the display/register-file board design.
- Takes a raw, bouncing, asynchronous button level and resynchronises it.
- Requires a stable press for a programmable number of cycles, then emits a single-cycle `pulse` per press.
- `pulse` drives register-file write enables and display page selects; `level` carries the debounced button state.

---
 rtl/seg_ui_pkg.sv | 7 +
 rtl/sync_2ff.sv | 14 +
 rtl/button_pulse_debouncer.sv | 102 ++++++++++
 tb/tb_button_pulse_debouncer.sv | 96 +++++++++
 4 files changed

// File: rtl/seg_ui_pkg.sv
// seg_ui_pkg: shared button FSM state type and default debounce timing
package seg_ui_pkg;
  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT} btn_state_t;
  localparam int DEF_STABLE_CYCLES = 1000000;
  localparam int DEF_REPEAT_DELAY = 50000000;
  localparam int DEF_REPEAT_PERIOD = 10000000;
endpackage

// File: rtl/sync_2ff.sv
// sync_2ff: 1-bit two-flop synchroniser with synchronous active-low reset
module sync_2ff (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);
  logic meta;
  // shift the asynchronous input through two flops to settle metastability
  always_ff @(posedge clk) begin
    if (!rst_n) {q, meta} <= 2'b00;
    else {q, meta} <= {meta, d};
  end
endmodule

// File: rtl/button_pulse_debouncer.sv
// button_pulse_debouncer: debounces a raw button into a level and one pulse per press (BTN_AUTOREPEAT_EN adds auto-repeat)
module button_pulse_debouncer
  import seg_ui_pkg::*;
#(
  parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
  parameter int REPEAT_DELAY = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD = DEF_REPEAT_PERIOD
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_raw,
  output logic pulse,
  output logic level,
  output logic busy
);
  localparam int MAX_A = STABLE_CYCLES > REPEAT_DELAY ? STABLE_CYCLES : REPEAT_DELAY;
  localparam int MAX_C = MAX_A > REPEAT_PERIOD ? MAX_A : REPEAT_PERIOD;
  localparam int CW = $clog2(MAX_C) + 1;
  localparam logic [CW-1:0] STB_LAST = CW'(STABLE_CYCLES - 1);
  if (STABLE_CYCLES < 2) begin : g_chk_stable
    $fatal(1, "STABLE_CYCLES must be at least 2");
  end
`ifdef BTN_AUTOREPEAT_EN
  if (REPEAT_PERIOD < 2) begin : g_chk_period
    $fatal(1, "REPEAT_PERIOD must be at least 2");
  end
  localparam logic [CW-1:0] DLY_LAST = CW'(REPEAT_DELAY - 1);
  localparam logic [CW-1:0] PER_LAST = CW'(REPEAT_PERIOD - 1);
  logic rep;
`endif
  btn_state_t state;
  logic btn_s;
  logic [CW-1:0] cnt, cnt_inc;
  sync_2ff u_sync (.clk(clk), .rst_n(rst_n), .d(btn_raw), .q(btn_s));
  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
  // debounce FSM with saturating counter; all outputs registered
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= RELEASED;
      cnt <= '0;
      pulse <= 1'b0;
      level <= 1'b0;
      busy <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
      rep <= 1'b0;
`endif
    end else begin
      pulse <= 1'b0;
      unique case (state)
        RELEASED:
          if (btn_s) begin
            state <= PRESS_WAIT;
            cnt <= '0;
            busy <= 1'b1;
          end
        PRESS_WAIT:
          if (!btn_s) begin
            state <= RELEASED;
            cnt <= '0;
            busy <= 1'b0;
          end else if (cnt == STB_LAST) begin
            state <= HELD;
            cnt <= '0;
            pulse <= 1'b1;
            level <= 1'b1;
            busy <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rep <= 1'b0;
`endif
          end else cnt <= cnt_inc;
        HELD:
          if (!btn_s) begin
            state <= RELEASE_WAIT;
            cnt <= '0;
            busy <= 1'b1;
          end
`ifdef BTN_AUTOREPEAT_EN
          else if (cnt == (rep ? PER_LAST : DLY_LAST)) begin
            cnt <= '0;
            pulse <= 1'b1;
            rep <= 1'b1;
          end else cnt <= cnt_inc;
`endif
        RELEASE_WAIT:
          if (btn_s) begin
            state <= HELD;
            cnt <= '0;
            busy <= 1'b0;
`ifdef BTN_AUTOREPEAT_EN
            rep <= 1'b0;
`endif
          end else if (cnt == STB_LAST) begin
            state <= RELEASED;
            cnt <= '0;
            level <= 1'b0;
            busy <= 1'b0;
          end else cnt <= cnt_inc;
        default: state <= RELEASED;
      endcase
    end
  end
endmodule

// File: tb/tb_button_pulse_debouncer.sv
// tb_button_pulse_debouncer: directed self-checking bench for button_pulse_debouncer
module tb_button_pulse_debouncer;
  logic clk, rst_n, btn_raw, pulse, level, busy;
  int n_chk = 0;
  int n_fail = 0;
  button_pulse_debouncer #(.STABLE_CYCLES(4), .REPEAT_DELAY(10), .REPEAT_PERIOD(3)) dut (
    .clk(clk), .rst_n(rst_n), .btn_raw(btn_raw), .pulse(pulse), .level(level), .busy(busy)
  );
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input int k, input logic obs, input logic exp);
    n_chk++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s k=%0d: observed %b expected %b", tag, k, obs, exp);
    end
  endtask
  task automatic chk3(input string tag, input int k, input logic ep, input logic el, input logic eb);
    chk({tag, "_pulse"}, k, pulse, ep);
    chk({tag, "_level"}, k, level, el);
    chk({tag, "_busy"}, k, busy, eb);
  endtask
  initial begin
    logic ep;
    rst_n = 1'b0;
    btn_raw = 1'b0;
    repeat (3) tick();
    chk3("reset", 0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    repeat (3) tick();
    chk3("idle", 0, 1'b0, 1'b0, 1'b0);
    btn_raw = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      chk3("clean", k, k == 7, k >= 7, k >= 3 && k <= 6);
    end
    btn_raw = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk3("release", k, 1'b0, k < 7, k >= 3 && k <= 6);
    end
    for (int k = 1; k <= 8; k++) begin
      btn_raw = ((k - 1) / 2) % 2 == 0;
      tick();
      chk("bounce_pulse", k, pulse, 1'b0);
      chk("bounce_level", k, level, 1'b0);
    end
    btn_raw = 1'b1;
    for (int k = 1; k <= 12; k++) begin
      tick();
      chk3("after_bounce", k, k == 7, k >= 7, k >= 3 && k <= 6);
    end
    btn_raw = 1'b0;
    tick();
    chk3("rel_bounce", 1, 1'b0, 1'b1, 1'b0);
    tick();
    chk3("rel_bounce", 2, 1'b0, 1'b1, 1'b0);
    btn_raw = 1'b1;
    for (int k = 3; k <= 30; k++) begin
`ifdef BTN_AUTOREPEAT_EN
      ep = k >= 15 && (k - 15) % 3 == 0;
`else
      ep = 1'b0;
`endif
      tick();
      chk3("rel_bounce", k, ep, 1'b1, k == 3 || k == 4);
    end
    btn_raw = 1'b0;
    for (int k = 1; k <= 8; k++) begin
      tick();
      chk3("release2", k, 1'b0, k < 7, k >= 3 && k <= 6);
    end
    btn_raw = 1'b1;
    for (int k = 1; k <= 4; k++) begin
      tick();
      chk3("pre_reset", k, 1'b0, 1'b0, k >= 3);
    end
    rst_n = 1'b0;
    tick();
    chk3("mid_reset", 0, 1'b0, 1'b0, 1'b0);
    rst_n = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      chk3("post_reset", k, k == 7, k >= 7, k >= 3 && k <= 6);
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
